// File: rtl/aq_mbist_pkg.sv
// Shared types and the March C- element table for the single-port SRAM BIST controller.
package aq_mbist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int NUM_ELEM = 6;
    localparam int ELEM_W   = 3;

    // Bit e of each table describes March element e:
    //   E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 dn(r0,w1)  E4 dn(r1,w0)  E5 up(r0)
    localparam logic [7:0] ELEM_DN      = 8'b0001_1000;  // 1 = descending address order
    localparam logic [7:0] ELEM_TWO_OPS = 8'b0001_1110;  // 1 = read then write per address
    localparam logic [7:0] ELEM_HAS_RD  = 8'b0011_1110;  // 1 = first op of the element is a read
    localparam logic [7:0] ELEM_RVAL    = 8'b0001_0100;  // value the read expects
    localparam logic [7:0] ELEM_WVAL    = 8'b0000_1010;  // value the write stores

    // The op at (element, phase) is a read only in phase 0 of a reading element.
    function automatic logic op_is_read(input logic [ELEM_W-1:0] e, input logic ph);
        return ELEM_HAS_RD[e] && !ph;
    endfunction

    // Last op at the current address: phase 1 for two-op elements, otherwise always.
    function automatic logic op_is_last(input logic [ELEM_W-1:0] e, input logic ph);
        return ELEM_TWO_OPS[e] ? ph : 1'b1;
    endfunction

endpackage

// File: rtl/aq_mbist_addr_gen.sv
// Up/down March address counter: load to the start of an element, step, flag the last address.
module aq_mbist_addr_gen #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  load_dn,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    logic dn;

    // Load picks the direction and start address; step walks toward the far end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            dn   <= 1'b0;
        end else if (load) begin
            dn   <= load_dn;
            addr <= load_dn ? '1 : '0;
        end else if (step) begin
            addr <= dn ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
        end
    end

    assign last = dn ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/aq_spsram_mbist_ctrl.sv
// March C- BIST initiator sitting between the functional requester and a single-port SRAM wrapper.
module aq_spsram_mbist_ctrl
    import aq_mbist_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 59,
    parameter int FCNT_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  BIST_START,
    output logic                  BIST_BUSY,
    output logic                  BIST_DONE,
    output logic                  BIST_FAIL,
    output logic [ADDR_WIDTH-1:0] BIST_FAIL_ADDR,
    output logic [FCNT_WIDTH-1:0] BIST_FAIL_CNT,
    input  logic [ADDR_WIDTH-1:0] F_A,
    input  logic                  F_CEN,
    input  logic [DATA_WIDTH-1:0] F_D,
    input  logic                  F_GWEN,
    input  logic [DATA_WIDTH-1:0] F_WEN,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic [DATA_WIDTH-1:0] D,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    input  logic [DATA_WIDTH-1:0] Q
);

    state_e                  state;
    logic [ELEM_W-1:0]       elem;
    logic [ELEM_W-1:0]       elem_nxt;
    logic                    phase;
    logic                    issue_done;
    logic                    issue;
    logic                    op_rd;
    logic                    op_last;

    logic                    bist_cen;
    logic                    bist_gwen;
    logic                    bist_rv;
    logic [ADDR_WIDTH-1:0]   bist_a;
    logic [DATA_WIDTH-1:0]   bist_d;
    logic [DATA_WIDTH-1:0]   bist_wen;

    logic                    cmp_vld_p1;
    logic                    cmp_exp_p1;
    logic [ADDR_WIDTH-1:0]   cmp_addr_p1;
    logic                    miscmp;

    logic                    ag_load;
    logic                    ag_load_dn;
    logic                    ag_step;
    logic                    ag_last;
    logic [ADDR_WIDTH-1:0]   ag_addr;

    function automatic logic [FCNT_WIDTH-1:0] sat_inc(input logic [FCNT_WIDTH-1:0] v);
        return (&v) ? v : v + FCNT_WIDTH'(1);
    endfunction

    aq_mbist_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_addr_gen (
        .clk     (CLK),
        .rst     (RST),
        .load    (ag_load),
        .load_dn (ag_load_dn),
        .step    (ag_step),
        .addr    (ag_addr),
        .last    (ag_last)
    );

    // Decode the current op and decide how the address counter moves.
    always_comb begin
        issue      = (state == RUN) && !issue_done;
        op_rd      = op_is_read(elem, phase);
        op_last    = op_is_last(elem, phase);
        elem_nxt   = elem + ELEM_W'(1);
        ag_load    = 1'b0;
        ag_load_dn = 1'b0;
        ag_step    = 1'b0;
        if (state == IDLE && BIST_START) begin
            ag_load    = 1'b1;
            ag_load_dn = ELEM_DN[0];
        end else if (issue && op_last) begin
            if (!ag_last) begin
                ag_step = 1'b1;
            end else if (elem != ELEM_W'(NUM_ELEM - 1)) begin
                ag_load    = 1'b1;
                ag_load_dn = ELEM_DN[elem_nxt];
            end
        end
    end

    // Read data returned this cycle belongs to the read tracked in the p1 register.
    assign miscmp = cmp_vld_p1 && (Q != {DATA_WIDTH{cmp_exp_p1}});

    // FSM, op sequencing, compare tracking and sticky status.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= IDLE;
            elem           <= '0;
            phase          <= 1'b0;
            issue_done     <= 1'b0;
            bist_cen       <= 1'b1;
            bist_gwen      <= 1'b0;
            bist_rv        <= 1'b0;
            cmp_vld_p1     <= 1'b0;
            BIST_DONE      <= 1'b0;
            BIST_FAIL      <= 1'b0;
            BIST_FAIL_ADDR <= '0;
            BIST_FAIL_CNT  <= '0;
        end else begin
            // p0 -> p1: the read on the bus now returns data next cycle
            cmp_vld_p1 <= (state == RUN) && !bist_cen && !bist_gwen;

            if (miscmp) begin
                BIST_FAIL     <= 1'b1;
                BIST_FAIL_CNT <= sat_inc(BIST_FAIL_CNT);
                if (!BIST_FAIL) begin
                    BIST_FAIL_ADDR <= cmp_addr_p1;
                end
            end

            case (state)
                IDLE: begin
                    if (BIST_START) begin
                        state          <= RUN;
                        elem           <= '0;
                        phase          <= 1'b0;
                        issue_done     <= 1'b0;
                        BIST_DONE      <= 1'b0;
                        BIST_FAIL      <= 1'b0;
                        BIST_FAIL_ADDR <= '0;
                        BIST_FAIL_CNT  <= '0;
                    end
                end
                RUN: begin
                    if (issue_done) begin
                        state      <= DRAIN;
                        bist_cen   <= 1'b1;
                        issue_done <= 1'b0;
                    end else begin
                        bist_cen  <= 1'b0;
                        bist_gwen <= !op_rd;
                        bist_rv   <= ELEM_RVAL[elem];
                        if (!op_last) begin
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (ag_last) begin
                                if (elem == ELEM_W'(NUM_ELEM - 1)) begin
                                    issue_done <= 1'b1;
                                end else begin
                                    elem <= elem_nxt;
                                end
                            end
                        end
                    end
                end
                DRAIN: begin
                    state     <= IDLE;
                    BIST_DONE <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered SRAM address/data and the compare tag, captured alongside each op.
    always_ff @(posedge CLK) begin
        if (issue) begin
            bist_a   <= ag_addr;
            bist_d   <= op_rd ? '0 : {DATA_WIDTH{ELEM_WVAL[elem]}};
            bist_wen <= op_rd ? '0 : '1;
        end
        cmp_addr_p1 <= bist_a;
        cmp_exp_p1  <= bist_rv;
    end

    assign BIST_BUSY = (state != IDLE);
    assign A         = BIST_BUSY ? bist_a    : F_A;
    assign CEN       = BIST_BUSY ? bist_cen  : F_CEN;
    assign D         = BIST_BUSY ? bist_d    : F_D;
    assign GWEN      = BIST_BUSY ? bist_gwen : F_GWEN;
    assign WEN       = BIST_BUSY ? bist_wen  : F_WEN;

endmodule

// File: tb/tb_aq_spsram_mbist_ctrl.sv
// Testbench for aq_spsram_mbist_ctrl: SRAM model with stuck-at faults and a March C- reference model.
module tb_aq_spsram_mbist_ctrl;

    localparam int AW      = 8;
    localparam int DW      = 59;
    localparam int FCW     = 8;
    localparam int DEPTH   = 256;
    localparam int NOPS    = 2560;
    localparam int RUN_CYC = 2562;

    // March C- as written: direction and op codes per element (0=w0 1=w1 2=r0 3=r1 -1=none)
    localparam bit E_DN [6]    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam int E_OP [6][2] = '{'{0, -1}, '{2, 1}, '{3, 0}, '{2, 1}, '{3, 0}, '{2, -1}};

    typedef struct packed {
        logic          rd;
        logic [AW-1:0] addr;
        logic          val;
    } op_t;

    logic           CLK;
    logic           RST;
    logic           BIST_START;
    logic           BIST_BUSY;
    logic           BIST_DONE;
    logic           BIST_FAIL;
    logic [AW-1:0]  BIST_FAIL_ADDR;
    logic [FCW-1:0] BIST_FAIL_CNT;
    logic [AW-1:0]  F_A;
    logic           F_CEN;
    logic [DW-1:0]  F_D;
    logic           F_GWEN;
    logic [DW-1:0]  F_WEN;
    logic [AW-1:0]  A;
    logic           CEN;
    logic [DW-1:0]  D;
    logic           GWEN;
    logic [DW-1:0]  WEN;
    logic [DW-1:0]  Q;

    logic [DW-1:0]  mem [DEPTH];
    logic [DW-1:0]  s0  [DEPTH];
    logic [DW-1:0]  s1  [DEPTH];
    op_t            exp_ops [$];

    int checks = 0;
    int errors = 0;

    aq_spsram_mbist_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FCNT_WIDTH(FCW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .BIST_START     (BIST_START),
        .BIST_BUSY      (BIST_BUSY),
        .BIST_DONE      (BIST_DONE),
        .BIST_FAIL      (BIST_FAIL),
        .BIST_FAIL_ADDR (BIST_FAIL_ADDR),
        .BIST_FAIL_CNT  (BIST_FAIL_CNT),
        .F_A            (F_A),
        .F_CEN          (F_CEN),
        .F_D            (F_D),
        .F_GWEN         (F_GWEN),
        .F_WEN          (F_WEN),
        .A              (A),
        .CEN            (CEN),
        .D              (D),
        .GWEN           (GWEN),
        .WEN            (WEN),
        .Q              (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SRAM model: bit-masked write, registered read with stuck-at faults applied
    always @(posedge CLK) begin
        if (CEN === 1'b0) begin
            if (GWEN) mem[A] <= (mem[A] & ~WEN) | (D & WEN);
            else      Q <= (mem[A] | s1[A]) & ~s0[A];
        end
    end

    task automatic build_ops();
        op_t o;
        int  code;
        exp_ops.delete();
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int p = 0; p < 2; p++) begin
                    code = E_OP[e][p];
                    if (code >= 0) begin
                        o.rd   = (code >= 2);
                        o.addr = AW'(E_DN[e] ? DEPTH - 1 - i : i);
                        o.val  = code[0];
                        exp_ops.push_back(o);
                    end
                end
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            s0[i] = '0;
            s1[i] = '0;
        end
    endtask

    // Play the March op list against a faulty memory and collect the expected status
    task automatic ref_model(output logic efail, output logic [AW-1:0] eaddr, output logic [FCW-1:0] ecnt);
        logic [DW-1:0] rm [DEPTH];
        logic [DW-1:0] got;
        efail = 1'b0;
        eaddr = '0;
        ecnt  = '0;
        foreach (exp_ops[k]) begin
            if (!exp_ops[k].rd) begin
                rm[exp_ops[k].addr] = {DW{exp_ops[k].val}};
            end else begin
                got = (rm[exp_ops[k].addr] | s1[exp_ops[k].addr]) & ~s0[exp_ops[k].addr];
                if (got != {DW{exp_ops[k].val}}) begin
                    if (!efail) eaddr = exp_ops[k].addr;
                    efail = 1'b1;
                    if (ecnt != '1) ecnt = ecnt + FCW'(1);
                end
            end
        end
    endtask

    // Start a run, trace every bus op against the March list, count busy cycles and DONE rises
    task automatic run_bist(input int restart_at, output int busy_cyc, output int nops,
                            output int tbad, output int drises, output logic done_at_start);
        logic prev_done;
        int   cyc;
        op_t  o;
        tbad = 0; nops = 0; drises = 0; busy_cyc = 0; cyc = 0;
        @(negedge CLK);
        BIST_START = 1'b1;
        @(posedge CLK);
        #1;
        BIST_START    = 1'b0;
        done_at_start = BIST_DONE;
        prev_done     = BIST_DONE;
        if (BIST_BUSY) busy_cyc++;
        while (BIST_BUSY && cyc < 4000) begin
            @(posedge CLK);
            #1;
            cyc++;
            BIST_START = (cyc == restart_at);
            if (BIST_BUSY) busy_cyc++;
            if (BIST_DONE && !prev_done) drises++;
            prev_done = BIST_DONE;
            if (BIST_BUSY && CEN === 1'b0) begin
                if (nops < exp_ops.size()) begin
                    o = exp_ops[nops];
                    if (A !== o.addr || GWEN !== !o.rd ||
                        (!o.rd && (D !== {DW{o.val}} || WEN !== {DW{1'b1}}))) tbad++;
                end else begin
                    tbad++;
                end
                nops++;
            end
        end
        BIST_START = 1'b0;
        repeat (3) begin
            @(posedge CLK);
            #1;
            if (BIST_DONE && !prev_done) drises++;
            prev_done = BIST_DONE;
        end
    endtask

    // One complete BIST pass checked against the reference model
    task automatic test_march_run(input string name, input int restart_at);
        logic           efail, dstart;
        logic [AW-1:0]  eaddr;
        logic [FCW-1:0] ecnt;
        int             busy_cyc, nops, tbad, drises;
        ref_model(efail, eaddr, ecnt);
        run_bist(restart_at, busy_cyc, nops, tbad, drises, dstart);
        checks++; if (dstart !== 1'b0) begin errors++; $display("FAIL %s done_cleared_on_start: got %0b want 0", name, dstart); end
        checks++; if (busy_cyc !== RUN_CYC) begin errors++; $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cyc, RUN_CYC); end
        checks++; if (nops !== NOPS) begin errors++; $display("FAIL %s op_count: got %0d want %0d", name, nops, NOPS); end
        checks++; if (tbad !== 0) begin errors++; $display("FAIL %s op_trace: got %0d bad ops want 0", name, tbad); end
        checks++; if (drises !== 1) begin errors++; $display("FAIL %s done_rises: got %0d want 1", name, drises); end
        checks++; if (BIST_DONE !== 1'b1) begin errors++; $display("FAIL %s done: got %0b want 1", name, BIST_DONE); end
        checks++; if (BIST_FAIL !== efail) begin errors++; $display("FAIL %s fail: got %0b want %0b", name, BIST_FAIL, efail); end
        checks++; if (BIST_FAIL_ADDR !== eaddr) begin errors++; $display("FAIL %s fail_addr: got 0x%0h want 0x%0h", name, BIST_FAIL_ADDR, eaddr); end
        checks++; if (BIST_FAIL_CNT !== ecnt) begin errors++; $display("FAIL %s fail_cnt: got %0d want %0d", name, BIST_FAIL_CNT, ecnt); end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #1;
        checks++; if (BIST_BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", BIST_BUSY); end
        checks++; if (BIST_DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", BIST_DONE); end
        checks++; if (BIST_FAIL !== 1'b0) begin errors++; $display("FAIL rst_fail: got %0b want 0", BIST_FAIL); end
        checks++; if (BIST_FAIL_ADDR !== '0) begin errors++; $display("FAIL rst_fail_addr: got 0x%0h want 0", BIST_FAIL_ADDR); end
        checks++; if (BIST_FAIL_CNT !== '0) begin errors++; $display("FAIL rst_fail_cnt: got %0d want 0", BIST_FAIL_CNT); end
        checks++; if (CEN !== F_CEN || A !== F_A) begin errors++; $display("FAIL rst_passthru: got cen=%0b a=0x%0h want cen=%0b a=0x%0h", CEN, A, F_CEN, F_A); end
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge CLK);
        F_A = 8'h33; F_CEN = 1'b0; F_GWEN = 1'b1; F_D = DW'(16'h1234); F_WEN = '1;
        #1;
        checks++; if (A !== 8'h33 || CEN !== 1'b0 || GWEN !== 1'b1 || D !== DW'(16'h1234) || WEN !== {DW{1'b1}}) begin
            errors++; $display("FAIL pass_write: got a=0x%0h cen=%0b gwen=%0b d=0x%0h want a=0x33 cen=0 gwen=1 d=0x1234", A, CEN, GWEN, D);
        end
        @(negedge CLK);
        F_GWEN = 1'b0;
        @(negedge CLK);
        F_CEN = 1'b1;
        checks++; if (Q !== DW'(16'h1234)) begin errors++; $display("FAIL pass_readback: got 0x%0h want 0x1234", Q); end
        for (int i = 0; i < 4; i++) begin
            F_A = AW'($urandom); F_CEN = 1'($urandom); F_GWEN = 1'($urandom);
            F_D = DW'({$urandom, $urandom}); F_WEN = DW'({$urandom, $urandom});
            #1;
            checks++; if (A !== F_A || CEN !== F_CEN || GWEN !== F_GWEN || D !== F_D || WEN !== F_WEN) begin
                errors++; $display("FAIL pass_random%0d: got a=0x%0h cen=%0b d=0x%0h want a=0x%0h cen=%0b d=0x%0h", i, A, CEN, D, F_A, F_CEN, F_D);
            end
            @(negedge CLK);
        end
        F_CEN = 1'b1;
    endtask

    task automatic test_clean();
        clear_faults();
        test_march_run("clean", -1);
    endtask

    task automatic test_stuck1();
        clear_faults();
        s1[8'h5A] = DW'(1) << 17;
        test_march_run("stuck1_5a", -1);
    endtask

    task automatic test_two_faults();
        clear_faults();
        s0[8'h10] = DW'(1);
        s0[8'hF0] = DW'(1);
        test_march_run("two_faults", -1);
    endtask

    task automatic test_saturate();
        clear_faults();
        for (int i = 0; i < DEPTH; i++) s1[i] = '1;
        test_march_run("saturate", -1);
    endtask

    task automatic test_random_faults();
        int n;
        int a;
        for (int it = 0; it < 2; it++) begin
            clear_faults();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                if ($urandom_range(0, 1) == 1) s1[a] = s1[a] | (DW'(1) << $urandom_range(0, DW - 1));
                else                           s0[a] = s0[a] | (DW'(1) << $urandom_range(0, DW - 1));
            end
            test_march_run($sformatf("random%0d", it), -1);
        end
    endtask

    task automatic test_restart_ignored();
        clear_faults();
        test_march_run("restart_ignored", 500);
    endtask

    task automatic test_reset_mid_run();
        clear_faults();
        for (int i = 0; i < DEPTH; i++) s1[i] = '1;
        @(negedge CLK);
        BIST_START = 1'b1;
        @(negedge CLK);
        BIST_START = 1'b0;
        repeat (1000) @(posedge CLK);
        #1;
        checks++; if (BIST_FAIL !== 1'b1) begin errors++; $display("FAIL mid_fail_before_rst: got %0b want 1", BIST_FAIL); end
        F_CEN = 1'($urandom);
        F_GWEN = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checks++; if (BIST_BUSY !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0b want 0", BIST_BUSY); end
        checks++; if (BIST_DONE !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %0b want 0", BIST_DONE); end
        checks++; if (BIST_FAIL !== 1'b0 || BIST_FAIL_CNT !== '0) begin
            errors++; $display("FAIL mid_rst_status: got fail=%0b cnt=%0d want fail=0 cnt=0", BIST_FAIL, BIST_FAIL_CNT);
        end
        checks++; if (CEN !== F_CEN) begin errors++; $display("FAIL mid_rst_cen: got %0b want %0b", CEN, F_CEN); end
        @(negedge CLK);
        RST   = 1'b0;
        F_CEN = 1'b1;
        clear_faults();
        test_march_run("after_mid_rst", -1);
    endtask

    initial begin
        RST = 1'b1; BIST_START = 1'b0;
        F_A = AW'($urandom); F_CEN = 1'b1; F_D = '0; F_GWEN = 1'b0; F_WEN = '0;
        Q = '0;
        clear_faults();
        build_ops();
        test_reset();
        test_passthrough();
        test_clean();
        test_stuck1();
        test_two_faults();
        test_saturate();
        test_random_faults();
        test_restart_ignored();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
